// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among N_REQ byte sources.
// Captures the winning byte and parity, strobes the TX shifter and paces frames.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned TIMEOUT    = 2047,
  parameter int unsigned GAP_CYC    = 8,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ack,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_parity,
  output logic                      tx_load,
  input  logic                      tx_done,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int unsigned IdW  = $clog2(N_REQ);
  localparam int unsigned SumW = IdW + 1;
  localparam int unsigned TmrW = $clog2(TIMEOUT + 1);
  localparam int unsigned GapW = $clog2(GAP_CYC + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StWait, StGap} state_e;

  state_e             state_q, state_d;
  logic [IdW-1:0]     ptr_q, ptr_d;
  logic [IdW-1:0]     grant_q, grant_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               parity_q, parity_d;
  logic [TmrW-1:0]    timer_q, timer_d;
  logic [GapW-1:0]    gap_q, gap_d;

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic               win_valid;
  logic [IdW-1:0]     win_off;
  logic [SumW-1:0]    win_sum;
  logic [IdW-1:0]     win_idx;
  logic [DATA_W-1:0]  win_byte;

  // Rotate so bit 0 is the source just after the last winner; first set bit wins.
  assign req_dbl = {req, req};
  assign req_rot = N_REQ'(req_dbl >> ({1'b0, ptr_q} + 1'b1));

  always_comb begin
    win_valid = 1'b0;
    win_off   = '0;
    for (int unsigned o = 0; o < N_REQ; o++) begin
      if (!win_valid && req_rot[o]) begin
        win_valid = 1'b1;
        win_off   = IdW'(o);
      end
    end
  end

  assign win_sum  = {1'b0, ptr_q} + {1'b0, win_off} + 1'b1;
  assign win_idx  = (win_sum >= SumW'(N_REQ)) ? IdW'(win_sum - SumW'(N_REQ)) : IdW'(win_sum);
  assign win_byte = req_data[win_idx*DATA_W +: DATA_W];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    data_d      = data_q;
    parity_d    = parity_q;
    timer_d     = timer_q;
    gap_d       = gap_q;
    req_ack     = '0;
    tx_load     = 1'b0;
    timeout_err = 1'b0;
    busy        = (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (win_valid) begin
          ptr_d    = win_idx;
          grant_d  = win_idx;
          data_d   = win_byte;
          parity_d = (^win_byte) ^ (PARITY_ODD != 0);
          state_d  = StLoad;
        end
      end
      StLoad: begin
        req_ack = N_REQ'(1) << grant_q;
        tx_load = 1'b1;
        timer_d = '0;
        state_d = StWait;
      end
      StWait: begin
        timer_d = timer_q + 1'b1;
        // tx_done takes precedence over a coincident timeout
        if (tx_done) begin
          gap_d   = '0;
          state_d = StGap;
        end else if (timer_q == TmrW'(TIMEOUT - 1)) begin
          timeout_err = 1'b1;
          gap_d       = '0;
          state_d     = StGap;
        end
      end
      StGap: begin
        if (gap_q == GapW'(GAP_CYC - 1)) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      ptr_q    <= IdW'(N_REQ - 1);
      grant_q  <= '0;
      data_q   <= '0;
      parity_q <= 1'b0;
      timer_q  <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      data_q   <= data_d;
      parity_q <= parity_d;
      timer_q  <= timer_d;
      gap_q    <= gap_d;
    end
  end

  assign tx_data   = data_q;
  assign tx_parity = parity_q;
  assign grant_id  = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized frames checked
// against a transaction-level round-robin / timing model.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int TO  = 2047;
  localparam int GAP = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic            tx_done;

  logic [N-1:0]    req_ack,   o_req_ack;
  logic [DW-1:0]   tx_data,   o_tx_data;
  logic            tx_parity, o_tx_parity;
  logic            tx_load,   o_tx_load;
  logic [1:0]      grant_id,  o_grant_id;
  logic            busy,      o_busy;
  logic            timeout_err, o_timeout_err;

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .TIMEOUT(TO), .GAP_CYC(GAP), .PARITY_ODD(0)) u_dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_ack(req_ack),
    .tx_data(tx_data), .tx_parity(tx_parity), .tx_load(tx_load), .tx_done(tx_done),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .TIMEOUT(TO), .GAP_CYC(GAP), .PARITY_ODD(1)) u_dut_odd (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_ack(o_req_ack),
    .tx_data(o_tx_data), .tx_parity(o_tx_parity), .tx_load(o_tx_load), .tx_done(tx_done),
    .grant_id(o_grant_id), .busy(o_busy), .timeout_err(o_timeout_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int ptr_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // First requesting source after the previous winner, wrapping around.
  function automatic int pick(input logic [N-1:0] r, input int p);
    logic [N-1:0] rv;
    rv = r;
    for (int o = 1; o <= N; o++) begin
      if (rv[(p + o) % N]) return (p + o) % N;
    end
    return -1;
  endfunction

  function automatic logic parity_of(input logic [DW-1:0] b, input logic odd);
    return logic'($countones(b) % 2) ^ odd;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"},   req_ack, 0);
    check({tag, "_data"},  tx_data, 0);
    check({tag, "_par"},   tx_parity, 0);
    check({tag, "_load"},  tx_load, 0);
    check({tag, "_gid"},   grant_id, 0);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_terr"},  timeout_err, 0);
    check({tag, "_odd"},   {o_req_ack, o_tx_data, o_tx_parity, o_tx_load, o_grant_id,
                            o_busy, o_timeout_err}, 0);
  endtask

  // One complete frame, entered and left at the negedge of an IDLE cycle.
  // done_dly = WAIT cycle carrying tx_done (1 = cycle after tx_load), 0 = never.
  task automatic do_frame(input logic [N-1:0] r, input logic [N*DW-1:0] data, input int done_dly,
                          input bit hold, input bit gap_noise);
    int w, k_end;
    bit to_exp;
    logic [DW-1:0] b;
    @(negedge clk);
    req = r; req_data = data; tx_done = 1'b0;
    #1;
    check("idle_busy", busy, 0);
    check("idle_load", tx_load, 0);
    w = pick(r, ptr_m);
    ptr_m = w;
    b = data[w*DW +: DW];
    @(negedge clk); #1;
    check("ack", req_ack, 32'(1) << w);
    check("load", tx_load, 1);
    check("data", tx_data, b);
    check("par", tx_parity, parity_of(b, 1'b0));
    check("par_odd", o_tx_parity, parity_of(b, 1'b1));
    check("gid", grant_id, w);
    check("busy_load", busy, 1);
    if (!hold) req = req & ~(N'(1) << w);
    to_exp = !(done_dly > 0 && done_dly <= TO);
    k_end  = to_exp ? TO : done_dly;
    for (int k = 1; k <= k_end; k++) begin
      @(negedge clk);
      tx_done = (k == done_dly);
      #1;
      check("terr", timeout_err, (k == k_end) && to_exp);
      if (k == 1) check("wait_ack", {req_ack, tx_load}, 0);
    end
    for (int g = 1; g <= GAP; g++) begin
      @(negedge clk);
      tx_done = gap_noise && (g == 2);
      if (gap_noise && g == 3) req = 4'b1111;
      #1;
      check("gap_busy", busy, 1);
      check("gap_out", {req_ack, tx_load, timeout_err}, 0);
    end
    check("hold_data", {tx_data, grant_id}, {b, 2'(w)});
    tx_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = '0; req_data = '0; tx_done = 1'b0;
    ptr_m = N - 1;
    @(negedge clk); #1;
    check_all_zero("rst");
    rst = 1'b0;

    // All sources held: strict rotation 0,1,2,3,0,1
    for (int i = 0; i < 6; i++) do_frame(4'b1111, $urandom, $urandom_range(1, 12), 1'b1, 1'b0);

    // Single source, tx_done 20 cycles after tx_load
    do_frame(4'b0001, 32'h000000A5, 20, 1'b0, 1'b0);

    // Stuck transmitter on source 1, then the rotation continues from it
    do_frame(4'b0010, $urandom, 0, 1'b0, 1'b0);
    do_frame(4'b1111, $urandom, 5, 1'b0, 1'b0);

    // tx_done coincides with the timeout cycle
    do_frame(4'b0101, $urandom, TO, 1'b0, 1'b0);

    // Spurious tx_done and new requests during GAP
    do_frame(4'b0001, $urandom, 3, 1'b0, 1'b1);

    for (int i = 0; i < 20; i++) begin
      do_frame(N'($urandom_range(1, 15)), $urandom, $urandom_range(1, 40),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of WAIT
    @(negedge clk);
    req = 4'b0100; req_data = $urandom;
    @(negedge clk);
    req = '0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    ptr_m = N - 1;
    do_frame(4'b1000, 32'h07000000, 10, 1'b0, 1'b0);
    check("rst_gid3", grant_id, 3);
    check("rst_par", {tx_parity, o_tx_parity}, 2'b10);

    @(negedge clk); #1;
    check("end_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
